// File: rtl/audio_i2s_pkg.sv
// rtl/audio_i2s_pkg.sv - shared constants and FSM state type for the I2S transmit path
package audio_i2s_pkg;

    localparam int DEF_DATA_W     = 24;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// rtl/i2s_frame_fifo.sv - stereo frame FIFO with valid/ready push, pop strobe and level
module i2s_frame_fifo
    import audio_i2s_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATA_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Ready and empty come straight from the registered level, so both
    // decisions in a cycle see the state from before that cycle.
    assign full       = (level_q == LW'(DEPTH));
    assign empty      = (level_q == '0);
    assign push_ready = ~reset & ~full;
    assign do_push    = push_valid & push_ready;
    assign do_pop     = pop & ~empty;
    assign pop_data   = mem[rd_ptr];
    assign level      = level_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S transmitter; I2S_TX_UNDERFLOW_CNT_EN adds a saturating underflow counter
module i2s_tx_serializer
    import audio_i2s_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_left,
    input  logic [DATA_W-1:0]             in_right,
    output logic                          sdata,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt
);

    localparam int CW = $clog2(DATA_W + 1);

    i2s_state_t          state;
    logic                bclk_q;
    logic                lr_prev;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   hold_r;
    logic [CW-1:0]       bits_left;
    logic                bclk_fall;
    logic                bnd_to_left;
    logic                bnd_to_right;
    logic                fifo_empty;
    logic [2*DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0]   head_left;
    logic [DATA_W-1:0]   head_right;

    assign bclk_fall    = bclk_q & ~bclk;
    assign bnd_to_left  = bclk_fall & lr_prev & ~lrclk;
    assign bnd_to_right = bclk_fall & ~lr_prev & lrclk;
    assign head_left    = fifo_empty ? '0 : fifo_head[2*DATA_W-1:DATA_W];
    assign head_right   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

    i2s_frame_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_left, in_right}),
        .pop        (bnd_to_left),
        .pop_data   (fifo_head),
        .empty      (fifo_empty),
        .level      (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bclk_q    <= 1'b0;
            lr_prev   <= 1'b0;
            shreg     <= '0;
            hold_r    <= '0;
            bits_left <= '0;
            sdata     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            bclk_q    <= bclk;
            underflow <= 1'b0;
            if (bclk_fall) begin
                lr_prev <= lrclk;
                sdata   <= 1'b0;
                // The boundary fall itself carries no data bit: the MSB goes
                // out one fall later, which is the I2S one-bit delay.
                if (bnd_to_left) begin
                    state     <= ST_LEFT;
                    shreg     <= head_left;
                    hold_r    <= head_right;
                    bits_left <= CW'(DATA_W);
                    underflow <= fifo_empty;
                end else if (bnd_to_right && state == ST_LEFT) begin
                    state     <= ST_RIGHT;
                    shreg     <= hold_r;
                    bits_left <= CW'(DATA_W);
                end else if (state != ST_IDLE && bits_left != '0) begin
                    sdata     <= shreg[DATA_W-1];
                    shreg     <= shreg << 1;
                    bits_left <= bits_left - 1'b1;
                end
            end
        end
    end

`ifdef I2S_TX_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            uf_cnt <= '0;
        end else if (bnd_to_left && fifo_empty && uf_cnt != 16'hFFFF) begin
            uf_cnt <= uf_cnt + 16'd1;
        end
    end

    assign underflow_cnt = uf_cnt;
`else
    assign underflow_cnt = 16'd0;
`endif

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 24, bits per channel sample (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, stereo-frame FIFO depth (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  system clock; bclk/lrclk from the audio clock generator are synchronous to it.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bclk  input  1  bit clock level.
REQ-006 SHALL have port lrclk  input  1  word select level; 0 = left, 1 = right.
REQ-007 SHALL have port in_valid  input  1  stereo frame offered.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a frame.
REQ-009 SHALL have port in_left  input  DATA_W  left sample, two's complement.
REQ-010 SHALL have port in_right  input  DATA_W  right sample, two's complement.
REQ-011 SHALL have port sdata  output  1  serial I2S data.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse when a frame starts with the FIFO empty.
REQ-013 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  frames stored.
REQ-014 SHALL have port underflow_cnt  output  16  count of underflow events.

Function
REQ-015 SHALL register bclk and lrclk once; a bclk fall is when the registered value is 1 and the current value is 0.
REQ-016 SHALL act only on bclk-fall cycles; sdata SHALL update on the clk edge following that cycle.
REQ-017 SHALL require a bclk half-period of >=2 clk cycles (generator bclk divisor >=1); behaviour otherwise is undefined.
REQ-018 SHALL sample lrclk at each bclk fall and compare it with the value sampled at the previous fall; a difference is a slot boundary.
REQ-019 SHALL run the FSM states IDLE, LEFT, RIGHT; reset enters IDLE; sdata SHALL be 0 in IDLE.
REQ-020 SHALL go IDLE->LEFT only on a 1->0 lrclk boundary, LEFT->RIGHT on 0->1, RIGHT->LEFT on 1->0; other boundaries SHALL be ignored.
REQ-021 SHALL pop one FIFO frame at each 1->0 boundary and latch the left and right samples into holding registers.
REQ-022 SHALL, at the bclk fall after a boundary, drive the MSB of the new channel (I2S one-bit delay), then the next lower bit at each later fall.
REQ-023 SHALL drive 0 after DATA_W bits until the next boundary; slots shorter than DATA_W+1 falls SHALL truncate the LSBs.
REQ-024 SHALL, when the FIFO is empty at a pop, load zeros for both channels and pulse underflow for exactly 1 clk.
REQ-025 SHALL deassert in_ready when full; a push accepted in the same cycle as a pop SHALL be blocked only by the pre-cycle full state.
REQ-026 SHALL base a pop on the pre-cycle empty state; a push into an empty FIFO in the pop cycle SHALL still underflow, and the pushed frame SHALL be kept.
REQ-027 SHALL have fifo_level reflect push/pop one clk after the event; a simultaneous push and pop SHALL leave it unchanged.

Reset
REQ-028 SHALL, while reset is high, force sdata=0, underflow=0, in_ready=0, fifo_level=0 and underflow_cnt=0, empty the FIFO, and set the FSM to IDLE.
REQ-029 SHALL assert in_ready on the first cycle after reset is released.
REQ-030 SHALL abandon any partially shifted word and discard FIFO contents when reset is asserted mid-frame.

Configuration
REQ-031 SHALL, with I2S_TX_UNDERFLOW_CNT_EN defined, increment underflow_cnt on each underflow pulse, saturating at 16'hFFFF.
REQ-032 SHALL, without I2S_TX_UNDERFLOW_CNT_EN, tie underflow_cnt to 0 and include no counter logic; the underflow pulse is unaffected.

Structure
REQ-033 SHALL place the FSM state enum and the default DATA_W/FIFO_DEPTH constants in a shared package, audio_i2s_pkg.
REQ-034 SHALL implement the FIFO as the sub-module i2s_frame_fifo (width 2*DATA_W, synchronous reset, valid/ready push, pop strobe, level output).

Verification
REQ-035 SHALL verify: bclk every 4 clk, lrclk every 32 bclk, push L=24'hA5A5A5, R=24'h5A5A5A -> after the first 1->0 boundary, sdata equals the MSB-first sequences for L and R, each delayed one bclk, with 8 zero bits per slot.
REQ-036 SHALL verify: no push after reset, 2 frames elapse -> sdata stays 0, underflow pulses twice, underflow_cnt=2 with the macro and 0 without.
REQ-037 SHALL verify: 5 pushes with no bclk activity -> in_ready drops after the 4th, fifo_level=4, and the 5th frame is not stored.
REQ-038 SHALL verify: FIFO full, push held with a pop in the same cycle -> the push is rejected that cycle, fifo_level=3, and the push is accepted the next cycle.
REQ-039 SHALL verify: reset asserted mid-left-slot for 1 clk -> sdata=0 the next cycle, the FSM waits for the next 1->0 boundary, and fifo_level=0.
REQ-040 SHALL verify: lrclk every 16 bclk with DATA_W=24 -> each slot carries the 15 MSBs and the truncated LSBs are never output.
